// File: rtl/tsqr_stream_arbiter.sv
// Packet-granular round-robin merge of four AXI-Stream lanes into one registered stream.
// A lane keeps the grant until its TLAST beat is accepted; the block also reports per-packet beat counts.
module tsqr_stream_arbiter #(
    parameter int unsigned BW    = 32,
    parameter int unsigned BWB   = BW / 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                clk_line,
    input  logic                clk_line_rst_low,
    input  logic                enable,
    input  logic [3:0]          s_TVALID,
    input  logic [4*BW-1:0]     s_TDATA,
    input  logic [4*BWB-1:0]    s_TKEEP,
    input  logic [3:0]          s_TLAST,
    output logic [3:0]          s_TREADY,
    output logic                m_TVALID,
    output logic [BW-1:0]       m_TDATA,
    output logic [BWB-1:0]      m_TKEEP,
    output logic                m_TLAST,
    input  logic                m_TREADY,
    output logic [1:0]          grant_idx,
    output logic                busy,
    output logic                pkt_done,
    output logic [CNT_W-1:0]    pkt_beats
);

    localparam int unsigned NL = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state_q;
    logic [1:0]         grant_q;
    logic [1:0]         last_grant_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   pkt_beats_q;
    logic               pkt_done_q;
    logic               m_valid_q;
    logic [BW-1:0]      m_data_q;
    logic [BWB-1:0]     m_keep_q;
    logic               m_last_q;

    logic               pipe_ready;
    logic               accept;
    logic [3:0]         s_ready_c;
    logic [BW-1:0]      g_data;
    logic [BWB-1:0]     g_keep;
    logic               g_last;
    logic               g_valid;
    logic               sel_found_d;
    logic [1:0]         sel_idx_d;
    logic [CNT_W-1:0]   cnt_inc_d;

    // Round-robin search starting one past the most recently completed lane.
    always_comb begin
        sel_found_d = 1'b0;
        sel_idx_d   = last_grant_q + 2'd1;
        for (int unsigned i = 0; i < NL; i++) begin
            if (!sel_found_d && s_TVALID[last_grant_q + 2'(i + 1)]) begin
                sel_found_d = 1'b1;
                sel_idx_d   = last_grant_q + 2'(i + 1);
            end
        end
    end

    // Lane mux for the granted input.
    always_comb begin
        g_data  = '0;
        g_keep  = '0;
        g_last  = 1'b0;
        g_valid = 1'b0;
        for (int unsigned i = 0; i < NL; i++) begin
            if (grant_q == 2'(i)) begin
                g_data  = s_TDATA[i*BW +: BW];
                g_keep  = s_TKEEP[i*BWB +: BWB];
                g_last  = s_TLAST[i];
                g_valid = s_TVALID[i];
            end
        end
    end

    assign pipe_ready = !m_valid_q || m_TREADY;
    assign s_ready_c  = (state_q == LOCKED && pipe_ready) ? (4'b0001 << grant_q) : 4'b0000;
    assign accept     = (state_q == LOCKED) && pipe_ready && g_valid;
    assign cnt_inc_d  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
        if (!clk_line_rst_low) begin
            state_q      <= IDLE;
            grant_q      <= 2'd3;
            last_grant_q <= 2'd3;
            cnt_q        <= '0;
            pkt_beats_q  <= '0;
            pkt_done_q   <= 1'b0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_keep_q     <= '0;
            m_last_q     <= 1'b0;
        end else begin
            pkt_done_q <= 1'b0;

            // Output register: load on an accepted beat, drain when the core takes it.
            if (accept) begin
                m_valid_q <= 1'b1;
                m_data_q  <= g_data;
                m_keep_q  <= g_keep;
                m_last_q  <= g_last;
                cnt_q     <= cnt_inc_d;
            end else if (m_TREADY) begin
                m_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (enable && sel_found_d) begin
                        grant_q <= sel_idx_d;
                        cnt_q   <= '0;
                        state_q <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (accept && g_last) begin
                        last_grant_q <= grant_q;
                        pkt_done_q   <= 1'b1;
                        pkt_beats_q  <= cnt_inc_d;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_TREADY  = s_ready_c;
    assign m_TVALID  = m_valid_q;
    assign m_TDATA   = m_data_q;
    assign m_TKEEP   = m_keep_q;
    assign m_TLAST   = m_last_q;
    assign grant_idx = grant_q;
    assign busy      = (state_q == LOCKED);
    assign pkt_done  = pkt_done_q;
    assign pkt_beats = pkt_beats_q;

endmodule

// File: tb/tb_tsqr_stream_arbiter.sv
// Directed bench for tsqr_stream_arbiter: single lane, round-robin, back-pressure,
// enable/gap handling, counter saturation and asynchronous reset mid-packet.
module tb_tsqr_stream_arbiter;

    localparam int unsigned BW    = 32;
    localparam int unsigned BWB   = 4;
    localparam int unsigned CNT_W = 3;

    logic                clk      = 1'b0;
    logic                rst_n    = 1'b0;
    logic                enable   = 1'b0;
    logic                m_tready = 1'b0;
    logic [3:0]          s_tvalid = '0;
    logic [3:0]          s_tlast  = '0;
    logic [4*BW-1:0]     s_tdata  = '0;
    logic [4*BWB-1:0]    s_tkeep  = '0;
    logic [3:0]          s_tready;
    logic                m_tvalid;
    logic [BW-1:0]       m_tdata;
    logic [BWB-1:0]      m_tkeep;
    logic                m_tlast;
    logic [1:0]          grant_idx;
    logic                busy;
    logic                pkt_done;
    logic [CNT_W-1:0]    pkt_beats;

    int                  checks   = 0;
    int                  failures = 0;

    logic [BW-1:0]       lane_base [4];
    int unsigned         lane_len  [4];
    int unsigned         lane_beat [4];
    bit                  lane_act  [4];
    bit                  lane_rep  [4];
    logic [BW-1:0]       got [$];
    logic [3:0]          hs;

    tsqr_stream_arbiter #(.BW(BW), .BWB(BWB), .CNT_W(CNT_W)) dut (
        .clk_line         (clk),
        .clk_line_rst_low (rst_n),
        .enable           (enable),
        .s_TVALID         (s_tvalid),
        .s_TDATA          (s_tdata),
        .s_TKEEP          (s_tkeep),
        .s_TLAST          (s_tlast),
        .s_TREADY         (s_tready),
        .m_TVALID         (m_tvalid),
        .m_TDATA          (m_tdata),
        .m_TKEEP          (m_tkeep),
        .m_TLAST          (m_tlast),
        .m_TREADY         (m_tready),
        .grant_idx        (grant_idx),
        .busy             (busy),
        .pkt_done         (pkt_done),
        .pkt_beats        (pkt_beats)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_lanes();
        for (int i = 0; i < 4; i++) begin
            s_tvalid[i]            = lane_act[i];
            s_tdata[i*BW +: BW]    = lane_base[i] + BW'(lane_beat[i]);
            s_tkeep[i*BWB +: BWB]  = 4'hF;
            s_tlast[i]             = (lane_beat[i] == lane_len[i] - 1);
        end
        #1;
    endtask

    task automatic setup_lane(input int i, input logic [BW-1:0] base, input int unsigned len, input bit rep);
        lane_base[i] = base;
        lane_len[i]  = len;
        lane_beat[i] = 0;
        lane_act[i]  = 1'b1;
        lane_rep[i]  = rep;
    endtask

    // One clock: note handshakes, advance, then let the lane sources move on.
    task automatic cyc();
        hs = s_tready & s_tvalid;
        if (m_tvalid && m_tready) got.push_back(m_tdata);
        step();
        for (int i = 0; i < 4; i++) begin
            if (hs[i]) begin
                if (lane_beat[i] == lane_len[i] - 1) begin
                    lane_beat[i] = 0;
                    if (!lane_rep[i]) lane_act[i] = 1'b0;
                end else begin
                    lane_beat[i]++;
                end
            end
        end
        apply_lanes();
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        m_tready = 1'b1;
        enable   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            lane_act[i]  = 1'b0;
            lane_beat[i] = 0;
            lane_len[i]  = 1;
            lane_base[i] = '0;
            lane_rep[i]  = 1'b0;
        end
        apply_lanes();
        got.delete();
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset values
        do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));
        chk("rst_m_tdata", 64'(m_tdata), 64'(0));
        chk("rst_m_tkeep", 64'(m_tkeep), 64'(0));
        chk("rst_m_tlast", 64'(m_tlast), 64'(0));
        chk("rst_s_tready", 64'(s_tready), 64'(0));
        chk("rst_grant", 64'(grant_idx), 64'(3));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_pkt_done", 64'(pkt_done), 64'(0));
        chk("rst_pkt_beats", 64'(pkt_beats), 64'(0));

        // Single lane: lane 2, 4 beats A0..A3
        do_reset();
        setup_lane(2, 32'hA0, 4, 1'b0);
        apply_lanes();
        cyc();
        chk("sl_busy_c1", 64'(busy), 64'(1));
        chk("sl_grant_c1", 64'(grant_idx), 64'(2));
        chk("sl_sready_c1", 64'(s_tready), 64'(4'b0100));
        chk("sl_mvalid_c1", 64'(m_tvalid), 64'(0));
        for (int b = 0; b < 4; b++) begin
            cyc();
            chk("sl_mvalid", 64'(m_tvalid), 64'(1));
            chk("sl_mdata", 64'(m_tdata), 64'(32'hA0 + b));
            chk("sl_mlast", 64'(m_tlast), 64'(b == 3));
        end
        chk("sl_mkeep", 64'(m_tkeep), 64'(4'hF));
        chk("sl_pkt_done", 64'(pkt_done), 64'(1));
        chk("sl_pkt_beats", 64'(pkt_beats), 64'(4));
        chk("sl_grant_end", 64'(grant_idx), 64'(2));
        chk("sl_busy_end", 64'(busy), 64'(0));
        cyc();
        chk("sl_pkt_done_off", 64'(pkt_done), 64'(0));
        chk("sl_mvalid_off", 64'(m_tvalid), 64'(0));
        chk("sl_pkt_beats_hold", 64'(pkt_beats), 64'(4));

        // Round-robin: every lane streams 2-beat packets back to back
        do_reset();
        for (int i = 0; i < 4; i++) setup_lane(i, 32'h100 * i, 2, 1'b1);
        apply_lanes();
        for (int c = 1; c <= 15; c++) begin
            int ph;
            int ln;
            int q;
            cyc();
            ph = (c - 1) % 3;
            ln = ((c - 1) / 3) % 4;
            chk("rr_sready", 64'(s_tready), 64'((ph < 2) ? (4'b0001 << ln) : 4'b0000));
            if (ph == 0) chk("rr_grant", 64'(grant_idx), 64'(ln));
            chk("rr_pkt_done", 64'(pkt_done), 64'(ph == 2));
            q = c - 2;
            if (c >= 2 && (q % 3) < 2) begin
                chk("rr_mvalid", 64'(m_tvalid), 64'(1));
                chk("rr_mdata", 64'(m_tdata), 64'(32'h100 * ((q / 3) % 4) + (q % 3)));
                chk("rr_mlast", 64'(m_tlast), 64'((q % 3) == 1));
            end else begin
                chk("rr_mvalid_bubble", 64'(m_tvalid), 64'(0));
            end
        end

        // Back-pressure: m_TREADY 1,0,0,1 during a 3-beat packet on lane 1
        do_reset();
        setup_lane(1, 32'hB0, 3, 1'b0);
        apply_lanes();
        begin
            logic       bp_mtr  [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
            logic [3:0] bp_srdy [7] = '{4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
            logic       bp_mval [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
            logic [7:0] bp_mdat [7] = '{8'h00, 8'hB0, 8'hB0, 8'hB0, 8'hB1, 8'hB2, 8'h00};
            for (int c = 0; c < 7; c++) begin
                cyc();
                m_tready = bp_mtr[c];
                #1;
                chk("bp_sready", 64'(s_tready), 64'(bp_srdy[c]));
                chk("bp_mvalid", 64'(m_tvalid), 64'(bp_mval[c]));
                if (bp_mval[c]) chk("bp_mdata", 64'(m_tdata), 64'(bp_mdat[c]));
            end
        end
        chk("bp_beats_taken", 64'(got.size()), 64'(3));
        for (int i = 0; i < got.size(); i++) chk("bp_taken_data", 64'(got[i]), 64'(32'hB0 + i));
        chk("bp_pkt_beats", 64'(pkt_beats), 64'(3));

        // Enable dropped in beat 2 of a 5-beat packet; lane 1 must wait for enable
        do_reset();
        setup_lane(0, 32'hC0, 5, 1'b0);
        setup_lane(1, 32'hD0, 1, 1'b0);
        apply_lanes();
        cyc();
        chk("en_grant", 64'(grant_idx), 64'(0));
        cyc();
        enable = 1'b0;
        for (int c = 3; c <= 6; c++) cyc();
        chk("en_pkt_done", 64'(pkt_done), 64'(1));
        chk("en_pkt_beats", 64'(pkt_beats), 64'(5));
        cyc();
        cyc();
        chk("en_idle_busy", 64'(busy), 64'(0));
        chk("en_idle_sready", 64'(s_tready), 64'(0));
        chk("en_idle_grant", 64'(grant_idx), 64'(0));
        chk("en_beats_taken", 64'(got.size()), 64'(5));
        for (int i = 0; i < got.size(); i++) chk("en_taken_data", 64'(got[i]), 64'(32'hC0 + i));
        enable = 1'b1;
        cyc();
        chk("en_regrant_busy", 64'(busy), 64'(1));
        chk("en_regrant_grant", 64'(grant_idx), 64'(1));
        chk("en_regrant_sready", 64'(s_tready), 64'(4'b0010));

        // Granted lane 2 goes quiet for 3 cycles while lane 3 waits
        do_reset();
        setup_lane(2, 32'hE0, 4, 1'b0);
        setup_lane(3, 32'h30, 2, 1'b1);
        apply_lanes();
        cyc();
        cyc();
        lane_act[2] = 1'b0;
        apply_lanes();
        for (int c = 0; c < 3; c++) begin
            cyc();
            chk("gap_busy", 64'(busy), 64'(1));
            chk("gap_grant", 64'(grant_idx), 64'(2));
            chk("gap_sready", 64'(s_tready), 64'(4'b0100));
        end
        lane_act[2] = 1'b1;
        apply_lanes();
        cyc();
        chk("gap_resume_mdata", 64'(m_tdata), 64'(32'hE1));
        cyc();
        chk("gap_resume_mdata2", 64'(m_tdata), 64'(32'hE2));
        cyc();
        chk("gap_last_mdata", 64'(m_tdata), 64'(32'hE3));
        chk("gap_pkt_beats", 64'(pkt_beats), 64'(4));
        cyc();
        chk("gap_next_grant", 64'(grant_idx), 64'(3));

        // Beat counter saturates at 2^CNT_W-1 for a 9-beat packet
        do_reset();
        setup_lane(1, 32'h900, 9, 1'b0);
        apply_lanes();
        for (int c = 1; c <= 10; c++) cyc();
        chk("sat_pkt_done", 64'(pkt_done), 64'(1));
        chk("sat_pkt_beats", 64'(pkt_beats), 64'(7));
        chk("sat_mdata", 64'(m_tdata), 64'(32'h908));

        // Asynchronous reset after beat 2 of lane 3
        do_reset();
        setup_lane(3, 32'hF0, 6, 1'b0);
        apply_lanes();
        cyc();
        cyc();
        cyc();
        chk("ar_pre_mdata", 64'(m_tdata), 64'(32'hF1));
        rst_n = 1'b0;
        #1;
        chk("ar_mvalid", 64'(m_tvalid), 64'(0));
        chk("ar_mdata", 64'(m_tdata), 64'(0));
        chk("ar_mlast", 64'(m_tlast), 64'(0));
        chk("ar_sready", 64'(s_tready), 64'(0));
        chk("ar_grant", 64'(grant_idx), 64'(3));
        chk("ar_busy", 64'(busy), 64'(0));
        setup_lane(0, 32'h50, 2, 1'b0);
        setup_lane(3, 32'hF0, 6, 1'b0);
        apply_lanes();
        #1;
        rst_n = 1'b1;
        cyc();
        chk("ar_post_grant", 64'(grant_idx), 64'(0));
        chk("ar_post_sready", 64'(s_tready), 64'(4'b0001));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tsqr_stream_arbiter.md
# tsqr_stream_arbiter

Packet-granular round-robin arbiter that merges the four AXI-Stream input lanes of the TSQR tile into the single stream consumed by the TSQR compute core. It runs in the `clk_line` domain between the NoC-facing `stream_in_*` lanes and the core input. Once a lane wins, it holds the grant until that lane's TLAST beat is accepted, so packets are never interleaved. It also reports per-packet beat counts for the tile's control registers.

## Interface
Parameters:
- `BW`, 32, data width per lane in bits.
- `BWB`, BW/8, TKEEP width per lane.
- `CNT_W`, 16, width of the beat counter.

Ports:
- `clk_line`  in  1  line clock; all logic is in this domain.
- `clk_line_rst_low`  in  1  asynchronous, active-low reset.
- `enable`  in  1  arbitration enable; sampled only in IDLE.
- `s_TVALID`  in  4  per-lane valid.
- `s_TDATA`  in  4*BW  lane i occupies bits [i*BW +: BW].
- `s_TKEEP`  in  4*BWB  lane i occupies bits [i*BWB +: BWB].
- `s_TLAST`  in  4  per-lane last.
- `s_TREADY`  out  4  per-lane ready; at most one bit high.
- `m_TVALID`  out  1  merged-stream valid (registered).
- `m_TDATA`  out  BW  merged data (registered).
- `m_TKEEP`  out  BWB  merged keep (registered).
- `m_TLAST`  out  1  merged last (registered).
- `m_TREADY`  in  1  core ready.
- `grant_idx`  out  2  lane currently or most recently granted.
- `busy`  out  1  high in LOCKED.
- `pkt_done`  out  1  one-cycle pulse when a TLAST beat is accepted from a lane.
- `pkt_beats`  out  CNT_W  beat count of the completed packet; valid while `pkt_done` is high and held afterwards.

## Operation
- States: IDLE and LOCKED.
- **IDLE:** `s_TREADY` is 0.
  - If `enable` is high and any `s_TVALID` bit is set, select the first valid lane searching upward from (last_grant+1) mod 4, with wrap-around.
  - Register the selection into `grant_idx` and go to LOCKED.
  - If `enable` is low, or no lane is valid, stay in IDLE.
- **LOCKED:**
  - Define pipe_ready = !m_TVALID || m_TREADY.
  - `s_TREADY[grant_idx]` = pipe_ready; all other ready bits are 0 (combinational).
  - On an accepted beat (s_TVALID[g] && s_TREADY[g]), load the output register with that lane's data, keep and last, and set `m_TVALID`=1.
  - If the output register is not reloaded and `m_TREADY` is high, clear `m_TVALID`.
- **Packet end:** when the accepted beat has TLAST=1:
  - last_grant <= grant_idx.
  - Pulse `pkt_done` on the following cycle.
  - Latch `pkt_beats` = beat count including the TLAST beat.
  - Return to IDLE.
- **Beat counter:** reset to 0 at grant. Increments per accepted beat and saturates at 2^CNT_W-1. It does not wrap.
- **`enable` low mid-packet:** no effect; the packet completes and the arbiter then stays in IDLE.
- **Granted lane drops TVALID mid-packet:** the grant is held; no timeout.
- **Output register under back-pressure:** holds its contents while `m_TVALID` && !`m_TREADY`. Data must not change while stalled.
- **Reset (asynchronous, any time, including mid-packet):**
  - Returns the block to IDLE with last_grant=3, so lane 0 has first priority.
  - Any partial packet is abandoned; no TLAST is generated.

## Timing
- Reset values:
  - `s_TREADY`=0, `m_TVALID`=0, `m_TDATA`=0, `m_TKEEP`=0, `m_TLAST`=0.
  - `grant_idx`=3, `busy`=0, `pkt_done`=0, `pkt_beats`=0, internal state IDLE.
- **Grant latency:** lane valid seen in IDLE at cycle 0; LOCKED and `s_TREADY` high in cycle 1; first beat on `m_*` in cycle 2.
- **Throughput:** one beat per cycle inside a packet while `m_TREADY`=1.
- **Between packets:** exactly one IDLE bubble cycle.
  - TLAST accepted in cycle k, IDLE in cycle k+1, next lane ready in cycle k+2.
- **`pkt_done`:** asserted in cycle k+1.
- **Combinational paths:** `m_TREADY` to `s_TREADY` is the only one; all `m_*` outputs come from flops.

## Test plan
- **Single lane:** lane 2 sends a 4-beat packet (data 0xA0..0xA3, TLAST on beat 4), `m_TREADY`=1.
  - Expect `m_*` to carry 0xA0..0xA3 in cycles 2-5 with `m_TLAST` on 0xA3.
  - Expect `pkt_done` pulse with `pkt_beats`=4 and `grant_idx`=2.
- **Round-robin:** all 4 lanes hold 2-beat packets continuously after reset.
  - Expect grant order 0,1,2,3,0.
  - Expect one bubble cycle between packets and no interleaving.
- **Back-pressure:** `m_TREADY` toggles 1,0,0,1 during a 3-beat packet.
  - Expect `m_TDATA` held stable while stalled, no beats lost or duplicated, and `s_TREADY` low only while the register is full and stalled.
- **Enable and gaps:**
  - Deassert `enable` in beat 2 of a 5-beat packet: all 5 beats are delivered, then the block stays IDLE with lane 1 valid until `enable` returns.
  - Granted lane drops TVALID for 3 cycles: the grant is held, and other valid lanes see `s_TREADY`=0.
- **Reset mid-packet:** assert `clk_line_rst_low`=0 asynchronously after beat 2 of lane 3.
  - Expect all outputs to take their reset values immediately.
  - After release with lanes 0 and 3 valid, lane 0 is granted first.
